// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: gates the receiver, parses E0/F0 prefixed sequences, tracks
// eight held keys and hands press/release events to a consumer through a one-entry buffer.
module ps2_scan_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned TO_W        = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       evt_ack,
  input  logic       clr_ovr,
  output logic       rx_en,
  output logic [7:0] key_held,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       evt_make,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT_CYC);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d, wd_inc;
  logic            rx_en_q;
  logic [7:0]      key_held_q, key_held_d;
  logic            evt_valid_q, evt_valid_d;
  logic [2:0]      evt_code_q, evt_code_d;
  logic            evt_make_q, evt_make_d;
  logic            overrun_q, overrun_d;
  logic            timeout_err_q, timeout_err_d;

  logic       is_ctrl, key_hit, dec_ext, dec_brk;
  logic [2:0] key_idx;
  logic       post, post_make, ovr_set;

  assign dec_ext = (state_q == StExt) || (state_q == StExtBrk);
  assign dec_brk = (state_q == StBrk) || (state_q == StExtBrk);
  assign wd_inc  = wd_q + TO_W'(1);

  // Arrow codes only map when an E0 prefix is pending; letters only without it.
  always_comb begin
    is_ctrl = rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    key_hit = 1'b1;
    key_idx = 3'd0;
    if (dec_ext) begin
      case (rx_data)
        8'h75:   key_idx = 3'd4;
        8'h72:   key_idx = 3'd5;
        8'h6B:   key_idx = 3'd6;
        8'h74:   key_idx = 3'd7;
        default: key_hit = 1'b0;
      endcase
    end else begin
      case (rx_data)
        8'h1C:   key_idx = 3'd0;
        8'h32:   key_idx = 3'd1;
        8'h21:   key_idx = 3'd2;
        8'h23:   key_idx = 3'd3;
        default: key_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    key_held_d    = key_held_q;
    post          = 1'b0;
    post_make     = 1'b0;
    timeout_err_d = 1'b0;
    if (!en) begin
      state_d = StIdle;
      wd_d    = '0;
    end else if (rx_done_tick) begin
      wd_d = '0;
      if (is_ctrl) begin
        state_d = StIdle;
      end else if (rx_data == 8'hE0) begin
        state_d = dec_brk ? StExtBrk : StExt;
      end else if (rx_data == 8'hF0) begin
        state_d = dec_ext ? StExtBrk : StBrk;
      end else begin
        state_d = StIdle;
        if (key_hit) begin
          if (!dec_brk && !key_held_q[key_idx]) begin
            key_held_d[key_idx] = 1'b1;
            post                = 1'b1;
            post_make           = 1'b1;
          end else if (dec_brk && key_held_q[key_idx]) begin
            key_held_d[key_idx] = 1'b0;
            post                = 1'b1;
          end
        end
      end
    end else if (state_q == StIdle) begin
      wd_d = '0;
    end else if (wd_inc == TimeoutVal) begin
      state_d       = StIdle;
      wd_d          = '0;
      timeout_err_d = 1'b1;
    end else begin
      wd_d = wd_inc;
    end
  end

  // A post into a full, un-acked buffer is dropped; set beats clear on the overrun flag.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_make_d  = evt_make_q;
    ovr_set     = 1'b0;
    if (post) begin
      if (evt_valid_q && !evt_ack) begin
        ovr_set = 1'b1;
      end else begin
        evt_valid_d = 1'b1;
        evt_code_d  = key_idx;
        evt_make_d  = post_make;
      end
    end else if (evt_ack) begin
      evt_valid_d = 1'b0;
    end
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wd_q          <= '0;
      rx_en_q       <= 1'b0;
      key_held_q    <= '0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= '0;
      evt_make_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      rx_en_q       <= en;
      key_held_q    <= key_held_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_make_q    <= evt_make_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rx_en       = rx_en_q;
  assign key_held    = key_held_q;
  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_make    = evt_make_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: scripted sequences with literal expectations, then random
// byte streams checked every cycle against a prefix-flag reference model.
module tb_ps2_scan_ctrl;

  localparam int Tmo = 100;

  logic       clk = 1'b0;
  logic       reset, en, rx_done_tick, evt_ack, clr_ovr;
  logic [7:0] rx_data;
  logic       rx_en, evt_valid, evt_make, overrun, timeout_err;
  logic [7:0] key_held;
  logic [2:0] evt_code;

  int tests = 0;
  int fails = 0;
  int shown = 0;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.TIMEOUT_CYC(Tmo), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .evt_ack(evt_ack), .clr_ovr(clr_ovr), .rx_en(rx_en), .key_held(key_held),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_make(evt_make), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [7:0] held;
    logic       valid;
    logic [2:0] code;
    logic       make;
    logic       ovr;
    logic       to;
    logic       rx_en;
    logic       ext;
    logic       brk;
    logic [31:0] wd;
  } model_t;

  model_t m;

  function automatic int lookup(input logic [7:0] b, input logic ext);
    logic [7:0] tab [8];
    tab = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
    lookup = -1;
    for (int i = 0; i < 8; i++) if (tab[i] == b && ((i >= 4) == ext)) lookup = i;
  endfunction

  // Prefix bytes accumulate as flags; any other byte consumes them.
  function automatic model_t step(input model_t c, input logic e, input logic tick,
                                  input logic [7:0] b, input logic ack, input logic clr);
    model_t n;
    logic   post, pmake;
    int     k;
    n = c; post = 0; pmake = 0; k = 0; n.to = 0;
    if (!e) begin
      n.ext = 0; n.brk = 0; n.wd = 0;
    end else if (tick) begin
      n.wd = 0;
      if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
        n.ext = 0; n.brk = 0;
      end else if (b == 8'hE0) n.ext = 1;
      else if (b == 8'hF0) n.brk = 1;
      else begin
        k = lookup(b, c.ext);
        if (k >= 0) begin
          if (!c.brk && !c.held[k]) begin n.held[k] = 1; post = 1; pmake = 1; end
          else if (c.brk && c.held[k]) begin n.held[k] = 0; post = 1; end
        end
        n.ext = 0; n.brk = 0;
      end
    end else if (c.ext || c.brk) begin
      n.wd = c.wd + 1;
      if (n.wd == Tmo) begin n.ext = 0; n.brk = 0; n.wd = 0; n.to = 1; end
    end else n.wd = 0;
    if (post && c.valid && !ack) n.ovr = 1;
    else begin
      if (post) begin n.valid = 1; n.code = 3'(k); n.make = pmake; end
      else if (ack) n.valid = 0;
      if (clr) n.ovr = 0;
    end
    n.rx_en = e;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else m <= step(m, en, rx_done_tick, rx_data, evt_ack, clr_ovr);
  end

  always @(negedge clk) begin
    tests++;
    if ({rx_en, key_held, evt_valid, evt_code, evt_make, overrun, timeout_err} !==
        {m.rx_en, m.held, m.valid, m.code, m.make, m.ovr, m.to}) begin
      fails++;
      if (shown < 20) begin
        shown++;
        $display("FAIL cycle t=%0t got rx_en=%b held=%h v=%b code=%0d mk=%b ovr=%b to=%b | required rx_en=%b held=%h v=%b code=%0d mk=%b ovr=%b to=%b",
                 $time, rx_en, key_held, evt_valid, evt_code, evt_make, overrun, timeout_err,
                 m.rx_en, m.held, m.valid, m.code, m.make, m.ovr, m.to);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic ack();
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int quiet;
    reset = 1'b1; en = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00;
    evt_ack = 1'b0; clr_ovr = 1'b0;
    #1 reset = 1'b0;
    cyc(2);
    chk("reset rx_en", {7'd0, rx_en}, 8'h00);
    chk("reset held", key_held, 8'h00);
    chk("reset valid", {7'd0, evt_valid}, 8'h00);
    reset = 1'b1;
    cyc(1);
    chk("rx_en follows en", {7'd0, rx_en}, 8'h01);

    send(8'h1C);
    chk("A press held", key_held, 8'h01);
    chk("A press evt", {evt_valid, evt_make, 3'd0, evt_code}, 8'hC0);
    ack();
    chk("ack empties", {7'd0, evt_valid}, 8'h00);
    send(8'hF0); send(8'h1C);
    chk("A release held", key_held, 8'h00);
    chk("A release evt", {evt_valid, evt_make, 3'd0, evt_code}, 8'h80);
    ack();

    send(8'hE0); send(8'h75);
    chk("UP press held", key_held, 8'h10);
    chk("UP press evt", {evt_valid, evt_make, 3'd0, evt_code}, 8'hC4);
    ack();
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("UP release evt", {evt_valid, evt_make, 3'd0, evt_code}, 8'h84);
    ack();
    send(8'h75);
    chk("bare 75 no evt", {evt_valid, key_held[6:0]}, 8'h00);

    send(8'h1C); ack(); send(8'h1C); send(8'h1C);
    chk("typematic held", key_held, 8'h01);
    chk("typematic no evt", {7'd0, evt_valid}, 8'h00);
    send(8'h32);
    send(8'hE0); send(8'h72);
    chk("overrun set", {7'd0, overrun}, 8'h01);
    chk("overrun code kept", {5'd0, evt_code}, 8'h01);
    chk("overrun held", key_held, 8'h23);
    clr_ovr = 1'b1; cyc(1); clr_ovr = 1'b0;
    chk("clr_ovr", {7'd0, overrun}, 8'h00);
    ack();
    send(8'hF0); send(8'h1C); ack();
    send(8'hF0); send(8'h32); ack();
    send(8'hE0); send(8'hF0); send(8'h72); ack();
    send(8'h1C);
    evt_ack = 1'b1; send(8'h32); evt_ack = 1'b0;
    chk("post+ack evt", {evt_valid, evt_make, 3'd0, evt_code}, 8'hC1);
    chk("post+ack no ovr", {7'd0, overrun}, 8'h00);
    chk("post+ack held", key_held, 8'h03);
    ack();
    send(8'hF0); send(8'h1C); ack();
    send(8'hF0); send(8'h32); ack();

    send(8'hE0);
    cyc(Tmo - 1);
    chk("no early timeout", {7'd0, timeout_err}, 8'h00);
    cyc(1);
    chk("timeout pulse", {7'd0, timeout_err}, 8'h01);
    cyc(1);
    chk("timeout one cycle", {7'd0, timeout_err}, 8'h00);
    send(8'h75);
    chk("75 after timeout", {evt_valid, key_held[6:0]}, 8'h00);

    en = 1'b0;
    send(8'h21);
    chk("en low ignores", {rx_en, evt_valid, key_held[5:0]}, 8'h00);
    en = 1'b1;
    cyc(1);

    send(8'h1C); send(8'hF0);
    chk("held before reset", key_held, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("async rst held", key_held, 8'h00);
    chk("async rst outs", {rx_en, evt_valid, evt_make, overrun, timeout_err, evt_code}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    send(8'h1C);
    chk("fresh press", {evt_valid, evt_make, 3'd0, evt_code}, 8'hC0);
    chk("fresh held", key_held, 8'h01);
    ack();

    quiet = 0;
    for (int i = 0; i < 6000; i++) begin
      int r;
      logic [7:0] codes [8];
      codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
      en      = ($urandom_range(0, 99) < 96);
      evt_ack = ($urandom_range(0, 99) < 30);
      clr_ovr = ($urandom_range(0, 99) < 5);
      if (quiet > 0) begin
        quiet--;
        rx_done_tick = 1'b0;
      end else begin
        rx_done_tick = ($urandom_range(0, 2) == 0);
        r = $urandom_range(0, 99);
        if (r < 50) rx_data = codes[$urandom_range(0, 7)];
        else if (r < 64) rx_data = 8'hE0;
        else if (r < 78) rx_data = 8'hF0;
        else if (r < 83) rx_data = 8'hFA;
        else rx_data = 8'($urandom);
        if ($urandom_range(0, 299) == 0) quiet = Tmo + 10;
      end
      if ($urandom_range(0, 1999) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    rx_done_tick = 1'b0; evt_ack = 1'b0; clr_ovr = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
